ctrl_seq: RTL and testbench
===========================

# ctrl_seq

Parametrised multi-cycle control sequencer for the model computer. It replaces the purely combinational control-signal decoder with an explicit fetch/execute state machine. The block decodes the IR opcode field internally, adds a stop/run state, optional I/O handshake wait states, a JZ branch, an illegal-opcode trap and a retired-instruction counter. It drives the same datapath strobes (PC, IR, RAM, register file, ALU, flag register, I/O port, address/data muxes).

## Interface
Parameters:
- OP_W, 4, opcode field width; the opcode is IR[IR_W-1 -: OP_W] and also drives au_ac.
- REG_AW, 2, register address width; dr = IR[2*REG_AW-1:REG_AW], sr = IR[REG_AW-1:0].
- IR_W, OP_W+2*REG_AW, instruction width (derived, not overridable).
- CNT_W, 16, retired-instruction counter width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ir  in  IR_W  current instruction register contents.
- g, z  in  1  greater / zero flags from the flag register.
- run  in  1  start pulse, honoured only in STOP.
- in_valid  in  1  input port has data.
- out_ready  in  1  output port can accept data.
- ir_ld, ram_re, ram_wr, pc_ld, pc_inc, reg_we, au_en, gf_en, in_en, out_en, mux_s  out  1  datapath strobes.
- s  out  2  RAM address select: 2'b10 MOVB, 2'b01 MOVC, else 2'b00.
- reg_sr, reg_dr  out  REG_AW  register selects, taken straight from ir.
- au_ac  out  OP_W  ALU operation, equal to the opcode field.
- halted  out  1  high while in STOP.
- illegal  out  1  sticky, set on an undefined opcode.
- instr_cnt  out  CNT_W  count of retired instructions.

## Operation
- Opcodes: 0 MOVA, 1 MOVB, 2 MOVC, 3 MOVD, 4 ADD, 5 SUB, 6 JMP, 7 JG, 8 IN, 9 OUT, 10 MOVI, 11 HALT, 12 JZ. Codes 13 and above are illegal.
- States: STOP, FETCH, EXEC, WAIT_IO.
- STOP: all strobes 0; halted=1. run=1 moves to FETCH.
- FETCH: ram_re=ir_ld=pc_inc=1, then EXEC.
- EXEC strobes:
  - mux_s = MOVA|MOVC|MOVI|ADD|SUB|IN.
  - reg_we = MOVA|MOVC|MOVD|MOVI|ADD|SUB|IN.
  - au_en = MOVA|MOVB|ADD|SUB|OUT.
  - gf_en = SUB.
  - ram_wr = MOVB.
  - ram_re = MOVC|MOVI.
  - pc_inc = MOVI.
  - pc_ld = JMP | (JG&g) | (JZ&z).
  - in_en = IN; out_en = OUT.
- EXEC exits:
  - HALT goes to STOP.
  - An illegal opcode sets illegal and goes to STOP.
  - IN/OUT whose handshake is not ready goes to WAIT_IO (see Configuration).
  - Everything else goes to FETCH.
- WAIT_IO:
  - Strobes stay 0 until the handshake input is high.
  - In that cycle the EXEC strobes for IN or OUT are asserted, then the state goes to FETCH.
- instr_cnt increments on each retirement: the cycle leaving EXEC or WAIT_IO toward FETCH, plus HALT. It wraps modulo 2^CNT_W. Illegal opcodes do not count.
- illegal clears only on reset.
- run outside STOP is ignored.

## Timing
- Strobes are combinational from state, ir, g, z, in_valid and out_ready.
- state, halted, illegal and instr_cnt are registered.
- Reset: state=STOP, halted=1, illegal=0, instr_cnt=0, all strobes 0. Reset mid-instruction aborts it with no partial retirement.
- Latency:
  - 2 cycles per instruction (FETCH + EXEC), including MOVI.
  - IN/OUT take 2 + N cycles, where N is the number of wait cycles.
  - run to first ir_ld: 1 cycle.
- Flags are sampled in the EXEC cycle.
- reg_sr, reg_dr and au_ac follow ir in every state.

## Configuration
- CTRL_SEQ_IO_HS_EN defined:
  - IN completes only when in_valid=1; OUT completes only when out_ready=1.
  - If the input is ready in EXEC, the instruction completes in EXEC with no WAIT_IO.
  - in_en/out_en act as the one-cycle acknowledge.
- Undefined: in_valid and out_ready are ignored, IN/OUT always complete in EXEC, and WAIT_IO is unreachable.

## Structure
- Package ctrl_seq_pkg holds:
  - the opcode localparams (OP_MOVA..OP_JZ);
  - the state enum typedef;
  - the s encodings S_DEF, S_MOVC, S_MOVB.
- One sub-module, ctrl_seq_dec: combinational opcode decoder giving a one-hot instruction vector plus an illegal bit. The FSM and counter stay in the top.

## Test plan
- Reset, then run=1 for one cycle → FETCH asserts ram_re, ir_ld, pc_inc; halted=0 next cycle.
- ir=8'b0100_0110 (ADD r1,r2) in EXEC → reg_we=mux_s=au_en=1, au_ac=4, reg_dr=1, reg_sr=2; instr_cnt 0→1.
- JG with g=0 then g=1, and JZ with z=1 → pc_ld=0, then 1, then 1; SUB asserts gf_en.
- With CTRL_SEQ_IO_HS_EN, IN with in_valid low for 3 cycles → WAIT_IO for 3 cycles, then in_en=reg_we=1 for one cycle; total 5 cycles.
- Opcode 14 → illegal=1, halted=1, instr_cnt unchanged; run restarts, illegal stays set.
- With CNT_W=4, 16 retirements → instr_cnt wraps to 0; HALT → STOP, strobes 0.

Source files
------------

// File: rtl/ctrl_seq_pkg.sv
// Shared definitions for the ctrl_seq control sequencer: opcode values,
// FSM state encoding and RAM address-select encodings.
package ctrl_seq_pkg;

  localparam int OP_MOVA = 0;
  localparam int OP_MOVB = 1;
  localparam int OP_MOVC = 2;
  localparam int OP_MOVD = 3;
  localparam int OP_ADD  = 4;
  localparam int OP_SUB  = 5;
  localparam int OP_JMP  = 6;
  localparam int OP_JG   = 7;
  localparam int OP_IN   = 8;
  localparam int OP_OUT  = 9;
  localparam int OP_MOVI = 10;
  localparam int OP_HALT = 11;
  localparam int OP_JZ   = 12;

  // Opcodes at or above NUM_OPS are undefined and trap.
  localparam int NUM_OPS = 13;

  typedef logic [NUM_OPS-1:0] instr_vec_t;

  typedef enum logic [1:0] {
    STOP    = 2'd0,
    FETCH   = 2'd1,
    EXEC    = 2'd2,
    WAIT_IO = 2'd3
  } state_e;

  localparam logic [1:0] S_DEF  = 2'b00;
  localparam logic [1:0] S_MOVC = 2'b01;
  localparam logic [1:0] S_MOVB = 2'b10;

  function automatic logic is_io(instr_vec_t v);
    return v[OP_IN] | v[OP_OUT];
  endfunction

endpackage

// File: rtl/ctrl_seq_if.sv
// Bundle of all datapath-facing signals of ctrl_seq. The sequencer is the
// slave side; the datapath (or a testbench) is the master side.
interface ctrl_seq_if #(
  parameter int OP_W   = 4,
  parameter int REG_AW = 2,
  parameter int CNT_W  = 16
);
  localparam int IR_W = OP_W + 2 * REG_AW;

  logic [IR_W-1:0]   ir;
  logic              g;
  logic              z;
  logic              run;
  logic              in_valid;
  logic              out_ready;

  logic              ir_ld;
  logic              ram_re;
  logic              ram_wr;
  logic              pc_ld;
  logic              pc_inc;
  logic              reg_we;
  logic              au_en;
  logic              gf_en;
  logic              in_en;
  logic              out_en;
  logic              mux_s;
  logic [1:0]        s;
  logic [REG_AW-1:0] reg_sr;
  logic [REG_AW-1:0] reg_dr;
  logic [OP_W-1:0]   au_ac;
  logic              halted;
  logic              illegal;
  logic [CNT_W-1:0]  instr_cnt;

  modport master (
    output ir, g, z, run, in_valid, out_ready,
    input  ir_ld, ram_re, ram_wr, pc_ld, pc_inc, reg_we, au_en, gf_en,
           in_en, out_en, mux_s, s, reg_sr, reg_dr, au_ac,
           halted, illegal, instr_cnt
  );

  modport slave (
    input  ir, g, z, run, in_valid, out_ready,
    output ir_ld, ram_re, ram_wr, pc_ld, pc_inc, reg_we, au_en, gf_en,
           in_en, out_en, mux_s, s, reg_sr, reg_dr, au_ac,
           halted, illegal, instr_cnt
  );

endinterface

// File: rtl/ctrl_seq_dec.sv
// Combinational opcode decoder: one-hot instruction vector plus a flag for
// opcodes outside the defined instruction set.
module ctrl_seq_dec
  import ctrl_seq_pkg::*;
#(
  parameter int OP_W = 4
) (
  input  logic [OP_W-1:0] opcode_i,
  output instr_vec_t      instr_o,
  output logic            illegal_o
);

  // NOTE: every always_comb output gets a default before any conditional
  // assignment, so no path can leave it unassigned and infer a latch.
  always_comb begin
    instr_o = '0;
    for (int i = 0; i < NUM_OPS; i++) begin
      instr_o[i] = (opcode_i == OP_W'(i));
    end
  end

  assign illegal_o = ~|instr_o;

endmodule

// File: rtl/ctrl_seq.sv
// Multi-cycle fetch/execute control sequencer with STOP state, JZ, illegal
// opcode trap and retired-instruction counter. Define CTRL_SEQ_IO_HS_EN to
// make IN/OUT wait on in_valid/out_ready through the WAIT_IO state.
module ctrl_seq
  import ctrl_seq_pkg::*;
#(
  parameter int OP_W   = 4,
  parameter int REG_AW = 2,
  parameter int CNT_W  = 16
) (
  input logic       clk,
  input logic       rst_n,
  ctrl_seq_if.slave bus
);

  localparam int IR_W = OP_W + 2 * REG_AW;

  state_e           state_q;
  logic             halted_q;
  logic             illegal_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  logic [OP_W-1:0]  opcode;
  instr_vec_t       instr;
  logic             dec_illegal;
  logic             hs_ok;
  logic             retire;

  assign opcode = bus.ir[IR_W-1 -: OP_W];

  ctrl_seq_dec #(
    .OP_W (OP_W)
  ) u_dec (
    .opcode_i  (opcode),
    .instr_o   (instr),
    .illegal_o (dec_illegal)
  );

  // hs_ok is low only while an IN/OUT is waiting for its port.
`ifdef CTRL_SEQ_IO_HS_EN
  assign hs_ok = !(instr[OP_IN]  && !bus.in_valid) &&
                 !(instr[OP_OUT] && !bus.out_ready);
`else
  logic unused_hs;
  assign unused_hs = bus.in_valid ^ bus.out_ready;
  assign hs_ok     = 1'b1;
`endif

  // An instruction retires in the cycle it leaves EXEC/WAIT_IO toward FETCH,
  // or on HALT; illegal opcodes never retire.
  assign retire = ((state_q == EXEC) && !dec_illegal && hs_ok) ||
                  ((state_q == WAIT_IO) && hs_ok);
  assign cnt_d  = cnt_q + {{(CNT_W-1){1'b0}}, retire};

  // Datapath strobes: decoded instruction strobes fire only in the cycle the
  // instruction actually completes, so in_en/out_en double as the I/O ack.
  always_comb begin
    bus.ir_ld  = 1'b0;
    bus.ram_re = 1'b0;
    bus.ram_wr = 1'b0;
    bus.pc_ld  = 1'b0;
    bus.pc_inc = 1'b0;
    bus.reg_we = 1'b0;
    bus.au_en  = 1'b0;
    bus.gf_en  = 1'b0;
    bus.in_en  = 1'b0;
    bus.out_en = 1'b0;
    bus.mux_s  = 1'b0;
    bus.s      = S_DEF;
    case (state_q)
      FETCH: begin
        bus.ram_re = 1'b1;
        bus.ir_ld  = 1'b1;
        bus.pc_inc = 1'b1;
      end
      EXEC, WAIT_IO: begin
        if (hs_ok) begin
          bus.mux_s  = instr[OP_MOVA] | instr[OP_MOVC] | instr[OP_MOVI] |
                       instr[OP_ADD]  | instr[OP_SUB]  | instr[OP_IN];
          bus.reg_we = instr[OP_MOVA] | instr[OP_MOVC] | instr[OP_MOVD] |
                       instr[OP_MOVI] | instr[OP_ADD]  | instr[OP_SUB]  |
                       instr[OP_IN];
          bus.au_en  = instr[OP_MOVA] | instr[OP_MOVB] | instr[OP_ADD] |
                       instr[OP_SUB]  | instr[OP_OUT];
          bus.gf_en  = instr[OP_SUB];
          bus.ram_wr = instr[OP_MOVB];
          bus.ram_re = instr[OP_MOVC] | instr[OP_MOVI];
          bus.pc_inc = instr[OP_MOVI];
          bus.pc_ld  = instr[OP_JMP] | (instr[OP_JG] & bus.g) |
                       (instr[OP_JZ] & bus.z);
          bus.in_en  = instr[OP_IN];
          bus.out_en = instr[OP_OUT];
          if (instr[OP_MOVB]) begin
            bus.s = S_MOVB;
          end else if (instr[OP_MOVC]) begin
            bus.s = S_MOVC;
          end
        end
      end
      default: ;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= STOP;
      halted_q  <= 1'b1;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      cnt_q <= cnt_d;
      case (state_q)
        STOP: begin
          if (bus.run) begin
            state_q  <= FETCH;
            halted_q <= 1'b0;
          end
        end
        FETCH: begin
          state_q <= EXEC;
        end
        EXEC: begin
          if (dec_illegal) begin
            state_q   <= STOP;
            halted_q  <= 1'b1;
            illegal_q <= 1'b1;
          end else if (instr[OP_HALT]) begin
            state_q  <= STOP;
            halted_q <= 1'b1;
          end else if (!hs_ok && is_io(instr)) begin
            state_q <= WAIT_IO;
          end else begin
            state_q <= FETCH;
          end
        end
        WAIT_IO: begin
          if (hs_ok) begin
            state_q <= FETCH;
          end
        end
        default: begin
          state_q  <= STOP;
          halted_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.reg_sr    = bus.ir[REG_AW-1:0];
  assign bus.reg_dr    = bus.ir[2*REG_AW-1:REG_AW];
  assign bus.au_ac     = opcode;
  assign bus.halted    = halted_q;
  assign bus.illegal   = illegal_q;
  assign bus.instr_cnt = cnt_q;

endmodule

// File: tb/tb_ctrl_seq.sv
// Scoreboard bench for ctrl_seq: an instruction-level reference model pushes
// the expected per-cycle outputs; a monitor compares them on the falling edge.
module tb_ctrl_seq;
  import ctrl_seq_pkg::*;

  localparam int OP_W   = 4;
  localparam int REG_AW = 2;
  localparam int CNT_W  = 4;
`ifdef CTRL_SEQ_IO_HS_EN
  localparam bit HS = 1'b1;
`else
  localparam bit HS = 1'b0;
`endif

  typedef struct packed {
    logic ir_ld, ram_re, ram_wr, pc_ld, pc_inc, reg_we, au_en, gf_en;
    logic in_en, out_en, mux_s;
    logic [1:0] s;
  } strb_t;

  typedef struct packed {
    strb_t             st;
    logic [REG_AW-1:0] sr;
    logic [REG_AW-1:0] dr;
    logic [OP_W-1:0]   ac;
    logic              halted;
    logic              illegal;
    logic [CNT_W-1:0]  cnt;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ctrl_seq_if #(.OP_W(OP_W), .REG_AW(REG_AW), .CNT_W(CNT_W)) bus ();

  ctrl_seq #(.OP_W(OP_W), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  obs_t  exp_q[$];
  string tag_q[$];
  int    checks = 0;
  int    errors = 0;

  // Reference model state: instructions retired, sticky trap, running/stopped.
  int cnt_m   = 0;
  bit ill_m   = 1'b0;
  bit running = 1'b0;

  // Strobes an instruction produces in its completing cycle.
  function automatic strb_t exec_ref(int op, bit gv, bit zv);
    strb_t r = '0;
    case (op)
      0:  begin r.mux_s = 1; r.reg_we = 1; r.au_en = 1; end
      1:  begin r.au_en = 1; r.ram_wr = 1; r.s = 2'b10; end
      2:  begin r.mux_s = 1; r.reg_we = 1; r.ram_re = 1; r.s = 2'b01; end
      3:  begin r.reg_we = 1; end
      4:  begin r.mux_s = 1; r.reg_we = 1; r.au_en = 1; end
      5:  begin r.mux_s = 1; r.reg_we = 1; r.au_en = 1; r.gf_en = 1; end
      6:  begin r.pc_ld = 1; end
      7:  begin r.pc_ld = gv; end
      8:  begin r.mux_s = 1; r.reg_we = 1; r.in_en = 1; end
      9:  begin r.au_en = 1; r.out_en = 1; end
      10: begin r.mux_s = 1; r.reg_we = 1; r.ram_re = 1; r.pc_inc = 1; end
      12: begin r.pc_ld = zv; end
      default: ;
    endcase
    return r;
  endfunction

  function automatic obs_t mk(strb_t st, logic [7:0] irv, bit hl);
    obs_t o;
    o.st      = st;
    o.sr      = irv[1:0];
    o.dr      = irv[3:2];
    o.ac      = irv[7:4];
    o.halted  = hl;
    o.illegal = ill_m;
    o.cnt     = CNT_W'(cnt_m);
    return o;
  endfunction

  // Apply one cycle of inputs and queue what the outputs must be this cycle.
  task automatic drive(input logic [7:0] irv, input bit gv, zv, runv, ivv, orv,
                       input strb_t st, input bit hl, input string tag);
    bus.ir        = irv;
    bus.g         = gv;
    bus.z         = zv;
    bus.run       = runv;
    bus.in_valid  = ivv;
    bus.out_ready = orv;
    exp_q.push_back(mk(st, irv, hl));
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic stop_cycle(input bit runv, input string tag);
    drive(8'($urandom), 1'($urandom), 1'($urandom), runv, 1'($urandom),
          1'($urandom), '0, 1'b1, tag);
    if (runv) running = 1'b1;
  endtask

  task automatic fetch_cycle();
    strb_t f = '0;
    f.ir_ld  = 1'b1;
    f.ram_re = 1'b1;
    f.pc_inc = 1'b1;
    drive(8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
          1'($urandom), 1'($urandom), f, 1'b0, "fetch");
  endtask

  // Whole instruction: FETCH, then EXEC plus `waits` port-not-ready cycles.
  task automatic instr(input int op, input int dr, input int sr, input bit gv,
                       input bit zv, input int waits, input string tag);
    logic [7:0] irv;
    int  nw;
    bit  hs, ivv, orv;
    fetch_cycle();
    irv = {op[3:0], dr[1:0], sr[1:0]};
    nw  = (HS && (op == 8 || op == 9)) ? waits : 0;
    for (int k = 0; k <= nw; k++) begin
      hs  = (k == nw);
      ivv = (HS && op == 8) ? hs : 1'($urandom);
      orv = (HS && op == 9) ? hs : 1'($urandom);
      drive(irv, gv, zv, 1'($urandom), ivv, orv,
            hs ? exec_ref(op, gv, zv) : strb_t'('0), 1'b0, tag);
    end
    if (op >= NUM_OPS) begin
      ill_m   = 1'b1;
      running = 1'b0;
    end else begin
      cnt_m++;
      if (op == 11) running = 1'b0;
    end
  endtask

  task automatic reset_cycle(input string tag);
    rst_n   = 1'b0;
    cnt_m   = 0;
    ill_m   = 1'b0;
    running = 1'b0;
    drive(8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
          1'($urandom), 1'($urandom), '0, 1'b1, tag);
    rst_n = 1'b1;
  endtask

  initial begin : monitor
    obs_t  e;
    obs_t  a;
    string t;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        a.st.ir_ld  = bus.ir_ld;
        a.st.ram_re = bus.ram_re;
        a.st.ram_wr = bus.ram_wr;
        a.st.pc_ld  = bus.pc_ld;
        a.st.pc_inc = bus.pc_inc;
        a.st.reg_we = bus.reg_we;
        a.st.au_en  = bus.au_en;
        a.st.gf_en  = bus.gf_en;
        a.st.in_en  = bus.in_en;
        a.st.out_en = bus.out_en;
        a.st.mux_s  = bus.mux_s;
        a.st.s      = bus.s;
        a.sr        = bus.reg_sr;
        a.dr        = bus.reg_dr;
        a.ac        = bus.au_ac;
        a.halted    = bus.halted;
        a.illegal   = bus.illegal;
        a.cnt       = bus.instr_cnt;
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL %s at %0t: got %h expected %h", t, $time, a, e);
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin : stimulus
    int op;
    rst_n         = 1'b0;
    bus.ir        = '0;
    bus.g         = 1'b0;
    bus.z         = 1'b0;
    bus.run       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_cycle("reset");
    stop_cycle(1'b0, "stop_idle");
    stop_cycle(1'b1, "run");

    instr(4, 1, 2, 1'b0, 1'b0, 0, "add_r1_r2");
    instr(7, 0, 1, 1'b0, 1'b0, 0, "jg_g0");
    instr(7, 2, 3, 1'b1, 1'b0, 0, "jg_g1");
    instr(12, 1, 0, 1'b0, 1'b1, 0, "jz_z1");
    instr(12, 3, 3, 1'b1, 1'b0, 0, "jz_z0");
    instr(5, 2, 1, 1'b0, 1'b0, 0, "sub");
    instr(1, 0, 3, 1'b0, 1'b0, 0, "movb");
    instr(2, 3, 0, 1'b0, 1'b0, 0, "movc");
    instr(8, 1, 0, 1'b0, 1'b0, 3, "in_wait3");
    instr(9, 0, 2, 1'b0, 1'b0, 2, "out_wait2");
    instr(8, 2, 0, 1'b0, 1'b0, 0, "in_ready");

    instr(14, 1, 1, 1'b0, 1'b0, 0, "illegal_op14");
    stop_cycle(1'b0, "trapped");
    stop_cycle(1'b1, "restart");
    for (int i = 0; i < 17; i++) instr(10, i % 4, 3 - i % 4, 1'b0, 1'b0, 0, "movi_wrap");
    instr(11, 0, 0, 1'b0, 1'b0, 0, "halt");
    stop_cycle(1'b0, "halted");

    for (int i = 0; i < 300; i++) begin
      if (!running) begin
        stop_cycle(1'($urandom), "rand_stop");
      end else begin
        op = ($urandom_range(0, 9) == 0) ? int'($urandom_range(11, 15))
                                         : int'($urandom_range(0, 12));
        instr(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              1'($urandom), 1'($urandom), int'($urandom_range(0, 3)), "rand");
      end
    end

    while (!running) stop_cycle(1'b1, "prep_mid_reset");
    fetch_cycle();
    reset_cycle("reset_mid_instr");
    stop_cycle(1'b0, "after_reset");

    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
